// File: rtl/bram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_portb_arbiter
// Purpose  : Round-robin request/grant arbiter sharing BRAM port B between the
//            image solver (S) and the dmn cell (D), with read-valid routing.
// Revision : 1.0 - initial release
// ============================================================================
module bram_portb_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // solver master
  input  logic                  s_req,
  output logic                  s_gnt,
  input  logic                  s_en,
  input  logic                  s_we,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [7:0]            s_din,
  output logic [7:0]            s_dout,
  output logic                  s_rvalid,
  // dmn master
  input  logic                  d_req,
  output logic                  d_gnt,
  input  logic                  d_en,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [7:0]            d_din,
  output logic [7:0]            d_dout,
  output logic                  d_rvalid,
  // BRAM port B
  output logic                  enb,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [7:0]            dinb,
  input  logic [7:0]            doutb,
  // status
  output logic                  busy,
  output logic                  access_err
);

  localparam logic c_OWNER_S = 1'b0;
  localparam logic c_OWNER_D = 1'b1;
  localparam int   c_LAST    = READ_LAT - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_S = 2'd1,
    ST_OWN_D = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_owner;
  logic [READ_LAT-1:0] r_tag_v;
  logic [READ_LAT-1:0] r_tag_o;
  logic                r_access_err;
  logic                w_rd_push;
  logic                w_drain_done;

  // ---------------------------------------------------------------------------
  // Ownership state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_req && d_req) begin
          w_state_nxt = (r_last_owner == c_OWNER_D) ? ST_OWN_S : ST_OWN_D;
        end else if (s_req) begin
          w_state_nxt = ST_OWN_S;
        end else if (d_req) begin
          w_state_nxt = ST_OWN_D;
        end
      end
      ST_OWN_S: begin
        if (!s_req) w_state_nxt = ST_DRAIN;
      end
      ST_OWN_D: begin
        if (!d_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin memory: the master that released last loses the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= c_OWNER_D;
    end else if (r_state == ST_OWN_S && !s_req) begin
      r_last_owner <= c_OWNER_S;
    end else if (r_state == ST_OWN_D && !d_req) begin
      r_last_owner <= c_OWNER_D;
    end
  end

  assign s_gnt = (r_state == ST_OWN_S);
  assign d_gnt = (r_state == ST_OWN_D);
  assign busy  = (r_state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Port-B mux: only the owner reaches the BRAM, zeros when nobody owns it
  // ---------------------------------------------------------------------------
  always_comb begin
    enb   = 1'b0;
    web   = 1'b0;
    addrb = '0;
    dinb  = '0;
    if (s_gnt) begin
      enb   = s_en;
      web   = s_we & s_en;
      addrb = s_addr;
      dinb  = s_din;
    end else if (d_gnt) begin
      enb   = d_en;
      web   = d_we & d_en;
      addrb = d_addr;
      dinb  = d_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline, aligned with the BRAM read latency
  // ---------------------------------------------------------------------------
  assign w_rd_push = enb & ~web;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      r_tag_o <= '0;
    end else begin
      r_tag_v[0] <= w_rd_push;
      r_tag_o[0] <= d_gnt ? c_OWNER_D : c_OWNER_S;
      for (int i = 1; i < READ_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_o[i] <= r_tag_o[i-1];
      end
    end
  end

  // A tag in the final stage exits this cycle, so only earlier stages block.
  always_comb begin
    w_drain_done = 1'b1;
    for (int i = 0; i < c_LAST; i++) begin
      if (r_tag_v[i]) w_drain_done = 1'b0;
    end
  end

  assign s_rvalid = r_tag_v[c_LAST] & (r_tag_o[c_LAST] == c_OWNER_S);
  assign d_rvalid = r_tag_v[c_LAST] & (r_tag_o[c_LAST] == c_OWNER_D);
  assign s_dout   = doutb;
  assign d_dout   = doutb;

  // ---------------------------------------------------------------------------
  // Sticky flag for strobes from a master without grant
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_access_err <= 1'b0;
    end else if ((s_en && !s_gnt) || (d_en && !d_gnt)) begin
      r_access_err <= 1'b1;
    end
  end

  assign access_err = r_access_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_portb_arbiter
// Purpose  : Directed self-checking bench with a read scoreboard and BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_portb_arbiter;

  localparam int AW = 18;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_req, s_en, s_we, d_req, d_en, d_we;
  logic [AW-1:0] s_addr, d_addr, addrb;
  logic [7:0]    s_din, d_din, s_dout, d_dout, dinb, doutb;
  logic          s_gnt, d_gnt, s_rvalid, d_rvalid, enb, web, busy, access_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  typedef struct {
    bit         owner;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  bram_portb_arbiter #(.ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_gnt(s_gnt), .s_en(s_en), .s_we(s_we), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .s_rvalid(s_rvalid),
    .d_req(d_req), .d_gnt(d_gnt), .d_en(d_en), .d_we(d_we), .d_addr(d_addr),
    .d_din(d_din), .d_dout(d_dout), .d_rvalid(d_rvalid),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .busy(busy), .access_err(access_err)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // BRAM model: unwritten locations hold pat(addr); reads return after RL cycles
  logic [7:0] mem     [0:1023];
  bit         written [0:1023];
  logic [7:0] pipe    [0:RL-1];

  always @(posedge clk) begin
    if (enb && web) begin
      mem[addrb[9:0]]     <= dinb;
      written[addrb[9:0]] <= 1'b1;
    end
    if (enb && !web) pipe[0] <= written[addrb[9:0]] ? mem[addrb[9:0]] : pat(int'(addrb[9:0]));
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign doutb = pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit owner, input logic [7:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    e.due   = cycle + RL;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every cycle, rvalids must match exactly what is due
  always @(negedge clk) begin
    bit         due_s;
    bit         due_d;
    logic [7:0] ed;
    due_s = 1'b0;
    due_d = 1'b0;
    ed    = 8'h00;
    if (sb.size() > 0 && sb[0].due == cycle) begin
      due_s = !sb[0].owner;
      due_d = sb[0].owner;
      ed    = sb[0].data;
    end
    chk("s_rvalid", {31'd0, s_rvalid}, {31'd0, due_s});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, due_d});
    if (due_s) chk("s_dout", {24'd0, s_dout}, {24'd0, ed});
    if (due_d) chk("d_dout", {24'd0, d_dout}, {24'd0, ed});
    if (due_s || due_d) void'(sb.pop_front());
  end

  initial begin
    rst = 1'b1;
    s_req = 0; s_en = 0; s_we = 0; s_addr = '0; s_din = '0;
    d_req = 0; d_en = 0; d_we = 0; d_addr = '0; d_din = '0;
    repeat (2) @(posedge clk);
    smp;
    chk("rst_s_gnt", s_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_enb", enb, 0);
    chk("rst_web", web, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", access_err, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dinb", dinb, 0);
    tick; rst = 1'b0;

    // Tie after reset goes to S, then S writes and reads back
    tick; s_req = 1; d_req = 1;
    smp; chk("gnt_latency", s_gnt, 0); chk("idle_busy0", busy, 0);
    tick; smp;
    chk("tie1_s_gnt", s_gnt, 1); chk("tie1_d_gnt", d_gnt, 0); chk("own_busy", busy, 1);
    tick; s_en = 1; s_we = 1; s_addr = 18'h00010; s_din = 8'hA5;
    smp;
    chk("wr_enb", enb, 1); chk("wr_web", web, 1);
    chk("wr_addrb", addrb, 32'h10); chk("wr_dinb", dinb, 32'hA5);
    tick; s_we = 0; push(1'b0, 8'hA5);
    smp; chk("rd_enb", enb, 1); chk("rd_web", web, 0);

    // D strobes while S owns the port
    tick; s_en = 0; d_en = 1; d_we = 1; d_addr = 18'h00055; d_din = 8'h3C;
    smp;
    chk("ill_enb", enb, 0); chk("ill_web", web, 0);
    chk("ill_addrb", addrb, 32'h10); chk("ill_dinb", dinb, 32'hA5);
    tick; d_en = 0; d_we = 0;
    smp; chk("ill_err", access_err, 1);

    // S releases with no read in flight: 1 DRAIN, 1 IDLE, then D
    tick; s_req = 0;
    smp; chk("rel_s_gnt", s_gnt, 1);
    tick; smp;
    chk("drain_s_gnt", s_gnt, 0); chk("drain_d_gnt", d_gnt, 0); chk("drain_busy", busy, 1);
    tick; smp; chk("idle_d_gnt", d_gnt, 0); chk("idle_busy", busy, 0);
    tick; smp; chk("hand_d_gnt", d_gnt, 1);

    // D releases; second tie must go to S again
    tick; d_req = 0;
    tick; smp; chk("d_drain_busy", busy, 1);
    tick; s_req = 1; d_req = 1;
    smp; chk("pre_tie2_busy", busy, 0);
    tick; smp; chk("tie2_s_gnt", s_gnt, 1); chk("tie2_d_gnt", d_gnt, 0);

    // S reads in its last owned cycle; D waits for that tag to exit
    tick; s_req = 0; s_en = 1; s_we = 0; s_addr = 18'h00010; push(1'b0, 8'hA5);
    smp; chk("last_rd_enb", enb, 1);
    tick; s_en = 0;
    smp; chk("dr1_d_gnt", d_gnt, 0); chk("dr1_busy", busy, 1);
    tick; smp; chk("dr2_d_gnt", d_gnt, 0); chk("dr2_busy", busy, 1);
    tick; smp; chk("dr3_d_gnt", d_gnt, 0); chk("dr3_busy", busy, 0);
    tick; smp; chk("dr4_d_gnt", d_gnt, 1);

    // Burst of 16 back-to-back D reads
    for (int a = 0; a < 16; a++) begin
      tick; d_en = 1; d_we = 0; d_addr = AW'(a); push(1'b1, pat(a));
      smp; chk("burst_addrb", addrb, 32'(a));
    end
    tick; d_en = 0; d_req = 0;
    repeat (4) tick;
    smp; chk("err_sticky", access_err, 1); chk("burst_end_busy", busy, 0);

    // Reset one cycle after an S read: no rvalid for it afterwards
    tick; s_req = 1;
    tick; s_en = 1; s_we = 0; s_addr = 18'h00005;
    smp; chk("pre_rst_s_gnt", s_gnt, 1);
    tick; s_en = 0; s_req = 0; rst = 1; sb.delete();
    #1;
    chk("mid_rst_s_gnt", s_gnt, 0);
    chk("mid_rst_enb", enb, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", access_err, 0);
    chk("mid_rst_s_rvalid", s_rvalid, 0);
    tick; rst = 0;
    repeat (5) tick;
    smp; chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
